square_gen: RTL

- Programmable square/PWM stimulus generator on the 100 MHz system clock; the transmit-side counterpart of the frequency/duty measurement block.
- Produces a square wave with programmable period and high time, both counted in clk_100M cycles.
- Always emits whole periods, so a downstream gated counter sees an integer number of cycles.
- Configuration goes through a valid/ready handshake and is applied only at a period boundary, so a period is never truncated.

---
 rtl/square_gen_pkg.sv | 20 ++
 rtl/square_gen_cfg.sv | 87 ++++++++
 rtl/square_gen.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/square_gen_pkg.sv
// Shared types and constants for the square/PWM stimulus generator.
// Optional burst mode is enabled by defining SQUARE_GEN_BURST_EN.
package square_gen_pkg;

    localparam int CNT_W_DEF      = 32;
    localparam int PERIOD_MIN_DEF = 2;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Operands are widened to 64 bits so one function serves any CNT_W up to 64.
    function automatic logic cfg_is_valid(input logic [63:0] period,
                                          input logic [63:0] high,
                                          input logic [63:0] period_min);
        return (period >= period_min) && (high <= period);
    endfunction

endpackage

// File: rtl/square_gen_cfg.sv
// Configuration handshake, validation, pending/active registers and error flag.
// With SQUARE_GEN_BURST_EN defined, a burst length travels with the configuration.
module square_gen_cfg
    import square_gen_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int PERIOD_MIN = PERIOD_MIN_DEF
) (
    input  logic             clk_100M,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_high,
`ifdef SQUARE_GEN_BURST_EN
    input  logic [CNT_W-1:0] cfg_burst,
    output logic [CNT_W-1:0] act_burst,
`endif
    input  logic             apply,
    output logic             pending,
    output logic [CNT_W-1:0] act_period,
    output logic [CNT_W-1:0] act_high,
    output logic [CNT_W-1:0] eff_high,
    output logic             cfg_err
);

    logic [CNT_W-1:0] pend_period;
    logic [CNT_W-1:0] pend_high;
    logic             ready_back;
    logic             handshake;
    logic             cfg_ok;
`ifdef SQUARE_GEN_BURST_EN
    logic [CNT_W-1:0] pend_burst;
`endif

    assign handshake = cfg_valid && cfg_ready;
    assign cfg_ok    = cfg_is_valid(64'(cfg_period), 64'(cfg_high), 64'(PERIOD_MIN));

    // High time the active register will hold after this edge; the FSM needs it at a wrap.
    assign eff_high  = apply ? pend_high : act_high;

    always_ff @(posedge clk_100M or posedge rst) begin
        if (rst) begin
            cfg_ready   <= 1'b1;
            cfg_err     <= 1'b0;
            pending     <= 1'b0;
            ready_back  <= 1'b0;
            pend_period <= '0;
            pend_high   <= '0;
            act_period  <= '0;
            act_high    <= '0;
`ifdef SQUARE_GEN_BURST_EN
            pend_burst  <= '0;
            act_burst   <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments let later statements override earlier ones
            // within one edge while every read still sees the pre-edge value.
            ready_back <= apply;
            if (ready_back) begin
                cfg_ready <= 1'b1;
            end
            if (apply) begin
                act_period <= pend_period;
                act_high   <= pend_high;
`ifdef SQUARE_GEN_BURST_EN
                act_burst  <= pend_burst;
`endif
                pending    <= 1'b0;
            end
            if (handshake) begin
                if (cfg_ok) begin
                    pend_period <= cfg_period;
                    pend_high   <= cfg_high;
`ifdef SQUARE_GEN_BURST_EN
                    pend_burst  <= cfg_burst;
`endif
                    pending     <= 1'b1;
                    cfg_ready   <= 1'b0;
                end else begin
                    cfg_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/square_gen.sv
// Programmable square/PWM generator emitting whole periods of clk_100M cycles.
// Define SQUARE_GEN_BURST_EN to add cfg_burst / burst_done (stop after N periods).
module square_gen
    import square_gen_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int PERIOD_MIN = PERIOD_MIN_DEF
) (
    input  logic             clk_100M,
    input  logic             rst,
    input  logic             enable,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_high,
`ifdef SQUARE_GEN_BURST_EN
    input  logic [CNT_W-1:0] cfg_burst,
    output logic             burst_done,
`endif
    output logic             square,
    output logic             period_start,
    output logic             busy,
    output logic [CNT_W-1:0] cycles_out,
    output logic             cfg_err
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;
    logic             square_q, square_d;
    logic             start_q, start_d;
    logic             burst_end;
    logic             apply;
    logic             wrap;
    logic             pending;
    logic [CNT_W-1:0] act_period;
    logic [CNT_W-1:0] act_high;
    logic [CNT_W-1:0] eff_high;
`ifdef SQUARE_GEN_BURST_EN
    logic [CNT_W-1:0] act_burst;
    logic             hold_q, hold_d;
    logic             done_q, done_d;
`endif

    square_gen_cfg #(
        .CNT_W      (CNT_W),
        .PERIOD_MIN (PERIOD_MIN)
    ) u_cfg (
        .clk_100M   (clk_100M),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_period (cfg_period),
        .cfg_high   (cfg_high),
`ifdef SQUARE_GEN_BURST_EN
        .cfg_burst  (cfg_burst),
        .act_burst  (act_burst),
`endif
        .apply      (apply),
        .pending    (pending),
        .act_period (act_period),
        .act_high   (act_high),
        .eff_high   (eff_high),
        .cfg_err    (cfg_err)
    );

    assign wrap  = (state_q == S_RUN) && (phase_q == act_period - ONE);
    assign apply = pending && ((state_q == S_IDLE) || wrap);

`ifdef SQUARE_GEN_BURST_EN
    assign burst_end = (act_burst != '0) && (cycles_q == act_burst - ONE);
`else
    assign burst_end = 1'b0;
`endif

    always_comb begin
        // NOTE: every comb output gets a default first, so no path can infer a latch.
        state_d  = state_q;
        phase_d  = phase_q;
        cycles_d = cycles_q;
        square_d = square_q;
        start_d  = 1'b0;
`ifdef SQUARE_GEN_BURST_EN
        hold_d   = hold_q;
        done_d   = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                square_d = 1'b0;
`ifdef SQUARE_GEN_BURST_EN
                if (!enable) hold_d = 1'b0;
`endif
                // A pending config is applied first so a period never starts on stale values.
                if (enable && (act_period != '0) && !pending
`ifdef SQUARE_GEN_BURST_EN
                    && !hold_q
`endif
                   ) begin
                    state_d  = S_RUN;
                    phase_d  = '0;
                    square_d = (act_high != '0);
                    start_d  = 1'b1;
                    cycles_d = '0;
                end
            end
            S_RUN: begin
                if (wrap) begin
                    if (cycles_q != '1) cycles_d = cycles_q + ONE;
                    if (enable && !burst_end) begin
                        phase_d  = '0;
                        square_d = (eff_high != '0);
                        start_d  = 1'b1;
                    end else begin
                        state_d  = S_IDLE;
                        square_d = 1'b0;
`ifdef SQUARE_GEN_BURST_EN
                        done_d   = burst_end;
                        hold_d   = burst_end;
`endif
                    end
                end else begin
                    phase_d  = phase_q + ONE;
                    square_d = (phase_q + ONE) < act_high;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_100M or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            phase_q  <= '0;
            cycles_q <= '0;
            square_q <= 1'b0;
            start_q  <= 1'b0;
`ifdef SQUARE_GEN_BURST_EN
            hold_q   <= 1'b0;
            done_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            cycles_q <= cycles_d;
            square_q <= square_d;
            start_q  <= start_d;
`ifdef SQUARE_GEN_BURST_EN
            hold_q   <= hold_d;
            done_q   <= done_d;
`endif
        end
    end

    assign square       = square_q;
    assign period_start = start_q;
    assign busy         = (state_q == S_RUN);
    assign cycles_out   = cycles_q;
`ifdef SQUARE_GEN_BURST_EN
    assign burst_done   = done_q;
`endif

endmodule
